// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Package    : risc_pkg
// Purpose    : Shared encodings for the fetch/PC holding stage. It holds the
//              PC source selects, the 4-bit branch condition codes and the
//              bit positions of the {N,Z,C,V} flags inside the PSW.
// Ports      : none (package)
// Revision   : 1.0 - initial release
// ============================================================================
package risc_pkg;

  // PC source select (PCSrc)
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RSVD   = 2'b11;

  // Branch condition codes (opcode[11:8])
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Flag bit positions within psw = {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module     : branch_cond_eval
// Purpose    : Combinational evaluation of a 4-bit branch condition code
//              against the registered PSW flags.
// Ports      : cond_i      [3:0] condition code (opcode[11:8])
//              psw_i       [3:0] registered flags {N,Z,C,V}
//              cond_true_o       1 when the condition holds
// Revision   : 1.0 - initial release
// ============================================================================
module branch_cond_eval
  import risc_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] psw_i,
  output logic       cond_true_o
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = psw_i[FLAG_N];
  assign w_z = psw_i[FLAG_Z];
  assign w_c = psw_i[FLAG_C];
  assign w_v = psw_i[FLAG_V];

  always_comb begin
    cond_true_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_true_o = w_z;
      COND_NE: cond_true_o = ~w_z;
      COND_CS: cond_true_o = w_c;
      COND_CC: cond_true_o = ~w_c;
      COND_MI: cond_true_o = w_n;
      COND_PL: cond_true_o = ~w_n;
      COND_VS: cond_true_o = w_v;
      COND_VC: cond_true_o = ~w_v;
      COND_HI: cond_true_o = w_c & ~w_z;
      COND_LS: cond_true_o = ~w_c | w_z;
      COND_GE: cond_true_o = (w_n == w_v);
      COND_LT: cond_true_o = (w_n != w_v);
      COND_GT: cond_true_o = ~w_z & (w_n == w_v);
      COND_LE: cond_true_o = w_z | (w_n != w_v);
      COND_AL: cond_true_o = 1'b1;
      COND_NV: cond_true_o = 1'b0;
      default: cond_true_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module     : fetch_pc_unit
// Purpose    : PC/IR/MDR/PSW holding stage behind the multi-cycle controller.
//              It applies the PCWrite/Branch/PCSrc/JAorJR/IRWrite/PSWEn
//              strobes and evaluates branch conditions on the registered PSW.
// Ports      : clk, rst                  clock, sync active-high reset
//              PCWrite, Branch           unconditional / conditional PC load
//              PCSrc[1:0], JAorJR        PC source select, jump kind
//              IRWrite, PSWEn            IR load, PSW load
//              mem_rdata, alu_result,
//              alu_out, reg_rs           data inputs (DATA_W)
//              alu_flags[3:0]            {N,Z,C,V} from the ALU
//              pc, opcode, mdr, psw      registered outputs
//              branch_taken              combinational Branch & cond_true
// Revision   : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
  import risc_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              Branch,
  input  logic [1:0]        PCSrc,
  input  logic              JAorJR,
  input  logic              IRWrite,
  input  logic              PSWEn,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] reg_rs,
  input  logic [3:0]        alu_flags,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] mdr,
  output logic [3:0]        psw,
  output logic              branch_taken
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] opcode_q;
  logic [DATA_W-1:0] mdr_q;
  logic [3:0]        psw_q;
  logic              w_cond_true;
  logic              w_pc_en;

  // Condition is judged on the registered PSW, so a PSWEn in the same cycle
  // only affects branches from the following cycle onward.
  branch_cond_eval u_cond (
    .cond_i      (opcode_q[11:8]),
    .psw_i       (psw_q),
    .cond_true_o (w_cond_true)
  );

  assign branch_taken = Branch & w_cond_true;
  assign w_pc_en      = PCWrite | branch_taken;

  always_comb begin
    pc_d = pc_q;
    case (PCSrc)
      PCSRC_ALU:    pc_d = alu_result;
      PCSRC_ALUOUT: pc_d = alu_out;
      // Absolute jump keeps the current PC page and replaces the low 11 bits.
      PCSRC_JUMP:   pc_d = JAorJR ? reg_rs
                                  : {pc_q[DATA_W-1:11], opcode_q[10:0]};
      default:      pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      opcode_q <= '0;
      mdr_q    <= '0;
      psw_q    <= '0;
    end else begin
      mdr_q <= mem_rdata;
      if (w_pc_en) pc_q     <= pc_d;
      if (IRWrite) opcode_q <= mem_rdata;
      if (PSWEn)   psw_q    <= alu_flags;
    end
  end

  assign pc     = pc_q;
  assign opcode = opcode_q;
  assign mdr    = mdr_q;
  assign psw    = psw_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module     : tb_fetch_pc_unit
// Purpose    : Self-checking bench for fetch_pc_unit: a table of directed
//              per-cycle vectors, a full condition/flag sweep and a reset
//              sequence with all strobes active.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, Branch, JAorJR, IRWrite, PSWEn;
  logic [1:0]  PCSrc;
  logic [15:0] mem_rdata, alu_result, alu_out, reg_rs;
  logic [3:0]  alu_flags;
  logic [15:0] pc, opcode, mdr;
  logic [3:0]  psw;
  logic        branch_taken;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .PCWrite      (PCWrite),
    .Branch       (Branch),
    .PCSrc        (PCSrc),
    .JAorJR       (JAorJR),
    .IRWrite      (IRWrite),
    .PSWEn        (PSWEn),
    .mem_rdata    (mem_rdata),
    .alu_result   (alu_result),
    .alu_out      (alu_out),
    .reg_rs       (reg_rs),
    .alu_flags    (alu_flags),
    .pc           (pc),
    .opcode       (opcode),
    .mdr          (mdr),
    .psw          (psw),
    .branch_taken (branch_taken)
  );

  typedef struct packed {
    logic        irw;
    logic        pcw;
    logic        br;
    logic        ja;
    logic        pswen;
    logic [1:0]  pcsrc;
    logic [15:0] mem;
    logic [15:0] ares;
    logic [15:0] aout;
    logic [15:0] rs;
    logic [3:0]  flags;
    logic        exp_bt;
    logic [15:0] exp_pc;
    logic [15:0] exp_op;
    logic [3:0]  exp_psw;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vec [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    PCWrite = 0; Branch = 0; JAorJR = 0; IRWrite = 0; PSWEn = 0;
    PCSrc = 2'b11; mem_rdata = 16'h0; alu_result = 16'h0; alu_out = 16'h0;
    reg_rs = 16'h0; alu_flags = 4'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference truth table: conditions come in complementary pairs, the odd
  // code being the inverse of the even one.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  initial begin
    //            irw pcw br ja pe src  mem      ares     aout     rs       flg  bt  pc       op       psw
    vec[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,16'h1025,16'h0001,16'h0000,16'h0000,4'h0,1'b0,16'h0001,16'h1025,4'h0};
    vec[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,16'hCE03,16'h0002,16'h0000,16'h0000,4'h0,1'b0,16'h0001,16'hCE03,4'h0};
    vec[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,16'hAAAA,16'h0000,16'h0010,16'h0000,4'h0,1'b1,16'h0010,16'hCE03,4'h0};
    vec[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,16'hC003,16'h0000,16'h0077,16'h0000,4'h0,1'b0,16'h0010,16'hC003,4'h0};
    vec[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,16'h5555,16'h0000,16'h0040,16'h0000,4'h0,1'b0,16'h0010,16'hC003,4'h0};
    vec[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,2'b01,16'h1234,16'h0000,16'h0040,16'h0000,4'h4,1'b0,16'h0010,16'hC003,4'h4};
    vec[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,16'h0F0F,16'h0000,16'h0040,16'h0000,4'h0,1'b1,16'h0040,16'hC003,4'h4};
    vec[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'b11,16'h0000,16'h0000,16'h0000,16'h0000,4'h0,1'b0,16'h0040,16'hC003,4'h0};
    vec[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'b01,16'h0001,16'h0000,16'h0016,16'h0000,4'h0,1'b0,16'h0016,16'hC003,4'h0};
    vec[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,16'h8035,16'h0000,16'h0000,16'h0000,4'h0,1'b0,16'h0016,16'h8035,4'h0};
    vec[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,16'h0000,16'h9999,16'h8888,16'h7777,4'h0,1'b0,16'h0035,16'h8035,4'h0};
    vec[11] = '{1'b0,1'b1,1'b0,1'b1,1'b0,2'b10,16'h0000,16'h9999,16'h8888,16'h1234,4'h0,1'b0,16'h1234,16'h8035,4'h0};
    vec[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b11,16'h0000,16'h9999,16'h8888,16'h4321,4'h0,1'b0,16'h1234,16'h8035,4'h0};
    vec[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,16'h0000,16'hFFFF,16'h0000,16'h0000,4'h0,1'b0,16'hFFFF,16'h8035,4'h0};
    vec[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000,16'h0001,16'h0000,4'h0,1'b0,16'h0000,16'h8035,4'h0};
    vec[15] = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,16'h0000,16'hF800,16'h0000,16'h0000,4'h0,1'b0,16'hF800,16'h8035,4'h0};
    vec[16] = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,16'h0000,16'h0000,16'h0000,16'h0000,4'h0,1'b0,16'hF835,16'h8035,4'h0};

    // Reset for two cycles
    idle();
    rst = 1'b1;
    step();
    step();
    chk("reset_pc", {16'h0, pc}, 32'h0);
    chk("reset_opcode", {16'h0, opcode}, 32'h0);
    chk("reset_mdr", {16'h0, mdr}, 32'h0);
    chk("reset_psw", {28'h0, psw}, 32'h0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      IRWrite    = vec[i].irw;
      PCWrite    = vec[i].pcw;
      Branch     = vec[i].br;
      JAorJR     = vec[i].ja;
      PSWEn      = vec[i].pswen;
      PCSrc      = vec[i].pcsrc;
      mem_rdata  = vec[i].mem;
      alu_result = vec[i].ares;
      alu_out    = vec[i].aout;
      reg_rs     = vec[i].rs;
      alu_flags  = vec[i].flags;
      #1;
      chk($sformatf("v%0d_branch_taken", i), {31'h0, branch_taken}, {31'h0, vec[i].exp_bt});
      step();
      chk($sformatf("v%0d_pc", i), {16'h0, pc}, {16'h0, vec[i].exp_pc});
      chk($sformatf("v%0d_opcode", i), {16'h0, opcode}, {16'h0, vec[i].exp_op});
      chk($sformatf("v%0d_psw", i), {28'h0, psw}, {28'h0, vec[i].exp_psw});
      chk($sformatf("v%0d_mdr", i), {16'h0, mdr}, {16'h0, vec[i].mem});
    end

    // Sweep every condition code against every flag pattern
    for (int c = 0; c < 16; c++) begin
      idle();
      IRWrite   = 1'b1;
      mem_rdata = {4'h0, c[3:0], 8'h5A};
      step();
      for (int f = 0; f < 16; f++) begin
        idle();
        PSWEn     = 1'b1;
        alu_flags = f[3:0];
        #1;
        chk($sformatf("sweep_c%0h_f%0h_nobranch", c, f), {31'h0, branch_taken}, 32'h0);
        step();
        idle();
        Branch = 1'b1;
        PCSrc  = 2'b11;
        #1;
        chk($sformatf("sweep_c%0h_f%0h", c, f), {31'h0, branch_taken},
            {31'h0, cond_model(c[3:0], f[3:0])});
        step();
      end
    end

    // Reset while every strobe is active
    idle();
    PCWrite = 1'b1; IRWrite = 1'b1; PSWEn = 1'b1; PCSrc = 2'b00;
    alu_result = 16'h7777; mem_rdata = 16'hFFFF; alu_flags = 4'hF;
    step();
    chk("pre_rst_pc", {16'h0, pc}, 32'h7777);
    chk("pre_rst_psw", {28'h0, psw}, 32'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk("midrst_pc", {16'h0, pc}, 32'h0);
    chk("midrst_opcode", {16'h0, opcode}, 32'h0);
    chk("midrst_psw", {28'h0, psw}, 32'h0);
    chk("midrst_mdr", {16'h0, mdr}, 32'h0);

    // Reserved PC source holds pc even with PCWrite
    PCWrite = 1'b1; PCSrc = 2'b11; alu_result = 16'hBEEF; alu_out = 16'hCAFE;
    step();
    chk("rsvd_hold_pc", {16'h0, pc}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
